// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state enum, parity-mode codes and frame helpers
// used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits);
        return 32'd1 + data_bits + ((parity_mode != 32'd0) ? 32'd1 : 32'd0) + stop_bits;
    endfunction

    // Unused upper bits must be zero so they do not disturb the reduction.
    function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
        logic result_s;
        case (mode)
            PAR_EVEN: result_s = ^data;
            PAR_ODD:  result_s = ~^data;
            default:  result_s = 1'b0;
        endcase
        return result_s;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: bit_tick is high on the last clock of each bit period.
// clear restarts the period so the next bit is full width.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned   CW   = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 32'd1);

    logic [CW-1:0] cnt_r;

    // Clock counter: 0..CLKS_PER_BIT-1, wraps after the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CW{1'b0}};
        end else if (clear || (cnt_r == LAST)) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + CW'(32'd1);
        end
    end

    assign bit_tick = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, LSB-first data, optional parity,
// 1 or 2 stop bits, one word per valid/ready handshake.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    if (CLKS_PER_BIT < 32'd2 || CLKS_PER_BIT > 32'd65535) begin : g_bad_clks
        $fatal(1, "uart_tx_cfg: CLKS_PER_BIT out of range 2..65535");
    end
    if (DATA_BITS < 32'd5 || DATA_BITS > 32'd9) begin : g_bad_data
        $fatal(1, "uart_tx_cfg: DATA_BITS out of range 5..9");
    end
    if (PARITY_MODE > 32'd2) begin : g_bad_parity
        $fatal(1, "uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 32'd1 || STOP_BITS > 32'd2) begin : g_bad_stop
        $fatal(1, "uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    localparam logic       HAS_PARITY = (PARITY_MODE != 32'd0);
    localparam logic [1:0] PAR_SEL    = 2'(PARITY_MODE);
    localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 32'd1);
    localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 32'd1);

    uart_state_e          state_r, state_next_s;
    logic [DATA_BITS-1:0] shift_r;
    logic [3:0]           bit_cnt_r;
    logic                 parity_r;
    logic                 tx_r, ready_r, busy_r, done_r;
    logic                 tx_next_s, ready_next_s, done_next_s;
    logic                 bit_tick_s, accept_s, frame_end_s, baud_clear_s;

    // Accepting on the frame-end edge lets held-valid words follow with no idle gap.
    assign frame_end_s  = (state_r == STOP) && bit_tick_s && (bit_cnt_r == LAST_STOP);
    assign accept_s     = tx_valid && (ready_r || frame_end_s);
    assign baud_clear_s = accept_s || (state_r == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear_s),
        .bit_tick(bit_tick_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = START;
                else          state_next_s = IDLE;
            end
            START: begin
                if (bit_tick_s) state_next_s = DATA;
                else            state_next_s = START;
            end
            DATA: begin
                if (bit_tick_s && (bit_cnt_r == LAST_DATA)) state_next_s = HAS_PARITY ? PARITY : STOP;
                else                                        state_next_s = DATA;
            end
            PARITY: begin
                if (bit_tick_s) state_next_s = STOP;
                else            state_next_s = PARITY;
            end
            STOP: begin
                if (frame_end_s) state_next_s = accept_s ? START : IDLE;
                else             state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output logic: next value of the registered line and handshake outputs.
    always_comb begin
        tx_next_s    = tx_r;
        ready_next_s = ready_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    tx_next_s    = 1'b0;
                    ready_next_s = 1'b0;
                end else begin
                    tx_next_s    = 1'b1;
                    ready_next_s = 1'b1;
                end
            end
            START: begin
                if (bit_tick_s) tx_next_s = shift_r[0];
                else            tx_next_s = 1'b0;
            end
            DATA: begin
                if (bit_tick_s && (bit_cnt_r == LAST_DATA)) tx_next_s = HAS_PARITY ? parity_r : 1'b1;
                else if (bit_tick_s)                        tx_next_s = shift_r[1];
                else                                        tx_next_s = shift_r[0];
            end
            PARITY: begin
                if (bit_tick_s) tx_next_s = 1'b1;
                else            tx_next_s = parity_r;
            end
            STOP: begin
                if (frame_end_s) begin
                    done_next_s  = 1'b1;
                    tx_next_s    = ~accept_s;
                    ready_next_s = ~accept_s;
                end else begin
                    tx_next_s    = 1'b1;
                end
            end
            default: begin
                tx_next_s    = 1'b1;
                ready_next_s = 1'b1;
            end
        endcase
    end

    // Datapath: shift register, bit counter and latched parity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r   <= {DATA_BITS{1'b0}};
            bit_cnt_r <= 4'd0;
            parity_r  <= 1'b0;
        end else if (accept_s) begin
            shift_r   <= tx_data;
            bit_cnt_r <= 4'd0;
            parity_r  <= parity_bit(9'(tx_data), PAR_SEL);
        end else if (bit_tick_s) begin
            case (state_r)
                DATA: begin
                    shift_r <= shift_r >> 1;
                    if (bit_cnt_r == LAST_DATA) bit_cnt_r <= 4'd0;
                    else                        bit_cnt_r <= bit_cnt_r + 4'd1;
                end
                STOP:    bit_cnt_r <= bit_cnt_r + 4'd1;
                default: bit_cnt_r <= 4'd0;
            endcase
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            tx_r    <= tx_next_s;
            ready_r <= ready_next_s;
            busy_r  <= ~ready_next_s;
            done_r  <= done_next_s;
        end
    end

    assign tx       = tx_r;
    assign tx_ready = ready_r;
    assign busy     = busy_r;
    assign tx_done  = done_r;

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised successor to the fixed 8-bit UART transmitter.
- Serialises one word per valid/ready handshake into an asynchronous frame: start bit, LSB-first data, optional even/odd parity, 1 or 2 stop bits.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits between a host-side producer (register bank or FIFO) and the serial line; the companion receiver is specified separately.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd; 3 is illegal.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset: low = reset asserted.
- tx_data  input  DATA_BITS  word to send; sampled only on accept.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block can accept a word.
- tx  output  1  serial line, idle high.
- busy  output  1  a frame is in progress.
- tx_done  output  1  one-cycle pulse when a frame's last stop bit completes.

Behaviour:
- Reset values, applied asynchronously while reset is low:
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - state=IDLE; all counters and the shift register cleared.
- Reset mid-frame: abort immediately, tx returns high without finishing the frame, and no tx_done pulse is generated.
- Accept: occurs on a rising edge where tx_valid && tx_ready.
  - On that same edge: tx_data is latched into the shift register, tx<=0, state<=START, busy<=1, tx_ready<=0, bit and clock counters cleared.
  - tx_data and tx_valid are ignored while tx_ready=0.
- Frame length: FRAME_BITS = 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS.
  - tx_ready is low for exactly FRAME_BITS*CLKS_PER_BIT cycles after the accept edge.
  - busy is the exact complement of tx_ready.
- States:
  - IDLE: tx=1; wait for accept.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive shift register bit 0, shift right on each bit tick; after DATA_BITS bits go to PARITY if PARITY_MODE!=0, otherwise STOP.
  - PARITY: drive the parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle's edge: state<=IDLE, tx_ready<=1, busy<=0, tx_done<=1 for one cycle.
- Parity:
  - even: ^data (total ones including parity is even).
  - odd: ~^data.
  - Computed from the latched word at accept, not from the shifted register.
- Bit timing:
  - The clock counter runs 0..CLKS_PER_BIT-1; bit_tick fires at CLKS_PER_BIT-1 and the counter wraps to 0.
  - The counter is cleared on accept, so the start bit is always full width.
- Back-to-back: if tx_valid is held high, the next accept happens on the same edge that returns to IDLE. tx goes 1 to 0 directly from the last stop bit, with no idle gap. This is legal because the stop bits are complete.
- tx is registered (glitch-free); tx is the only output that toggles on the line.
- Elaboration-time assertions on illegal parameter values.
- Counter widths: clock counter $clog2(CLKS_PER_BIT); bit counter 4 bits.

Decomposition:
- Shared package uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - parity-mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - function frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS), to be reused by the receiver.
- Sub-module uart_baud_tick (param CLKS_PER_BIT; inputs clk, reset, clear; output bit_tick). The receiver reuses it with a half-bit preload.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, even parity, 1 stop; send 0x67 → tx sequence 0,1,1,1,0,0,1,1,0,1,1 (each bit 4 cycles). tx_ready low for 44 cycles, tx_done pulse on cycle 44.
- Same config, odd parity, send 0xB5 → data 1,0,1,0,1,1,0,1, parity 0; with even parity, parity is 1.
- DATA_BITS=7, PARITY_MODE=0, STOP_BITS=2; send 0x55 → 0,1,0,1,0,1,0,1,1,1, i.e. 10 bits = 40 cycles; no parity slot.
- tx_valid held high with 0x0F then 0xF0 → second start bit falls on the exact edge after the first frame's stop bit ends; no idle gap; two tx_done pulses 44 cycles apart.
- Change tx_data and toggle tx_valid during a frame → frame unchanged, no extra accept.
- Assert reset (low) during the third data bit → tx=1, tx_ready=1, busy=0 immediately (asynchronous); no tx_done. After release, 0x3C is sent correctly.
